// File: rtl/core0_console_pkg.sv
// Shared console constants and types for the core0 uARC console bridge.
package core0_console_pkg;

  localparam int unsigned CONSOLE_BYTE_W = 8;
  localparam logic [31:0] STDIN_ADDR     = 32'h8000_0000;
  localparam logic [31:0] STDOUT_ADDR    = 32'h8000_0001;

  typedef logic [CONSOLE_BYTE_W-1:0] console_byte_t;

endpackage

// File: rtl/uarc_byte_fifo.sv
// Byte FIFO with first-word-fall-through head and a registered occupancy count.
module uarc_byte_fifo
  import core0_console_pkg::*;
#(
  parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  console_byte_t            push_data,
  input  logic                     pop,
  output console_byte_t            head,
  output logic                     empty,
  output logic                     full,
  output logic [FIFO_ADDR_WIDTH:0] level
);

  localparam int unsigned DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_L = (FIFO_ADDR_WIDTH+1)'(DEPTH);

  console_byte_t              mem_q [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_WIDTH:0]   level_q, level_d;
  logic                       do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == DEPTH_L);
  assign level = level_q;
  // Push is gated by the pre-edge full flag, so a pop while full frees space only next cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uarc_console_bridge.sv
// uARC console bus <-> byte-wide serial bridge: STDOUT words to TX bytes, RX bytes to STDIN words.
module uarc_console_bridge
  import core0_console_pkg::*;
#(
  parameter int unsigned WORD_WIDTH      = 32,
  parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     global_send,
  input  logic [WORD_WIDTH-1:0]    global_data,
  input  logic                     sender_enable,
  output logic                     sender_send_ack,
  output logic                     receiver_enable,
  output logic                     receiver_send,
  output logic [WORD_WIDTH-1:0]    receiver_data,
  input  logic                     receiver_send_ack,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     rx_ready,
  output logic [FIFO_ADDR_WIDTH:0] tx_level,
  output logic [FIFO_ADDR_WIDTH:0] rx_level
);

  logic                     ack_q, ack_d;
  logic                     accept;
  console_byte_t            tx_head, rx_head;
  logic                     tx_empty, tx_full, rx_empty, rx_full;
  logic [FIFO_ADDR_WIDTH:0] tx_lvl, rx_lvl;

  // The ack blocks a second accept of the same word; reset blocks any accept on the flush edge.
  assign accept = reset & global_send & sender_enable & ~tx_full & ~ack_q;
  assign ack_d  = accept;

  always_ff @(posedge clk) begin
    if (!reset) ack_q <= 1'b0;
    else        ack_q <= ack_d;
  end

  uarc_byte_fifo #(.FIFO_ADDR_WIDTH(FIFO_ADDR_WIDTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (accept),
    .push_data (global_data[7:0]),
    .pop       (tx_ready),
    .head      (tx_head),
    .empty     (tx_empty),
    .full      (tx_full),
    .level     (tx_lvl)
  );

  uarc_byte_fifo #(.FIFO_ADDR_WIDTH(FIFO_ADDR_WIDTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (receiver_send_ack),
    .head      (rx_head),
    .empty     (rx_empty),
    .full      (rx_full),
    .level     (rx_lvl)
  );

  // Every output is forced low while reset is held, independent of register state.
  assign sender_send_ack = reset & ack_q;
  assign receiver_enable = reset;
  assign receiver_send   = reset & ~rx_empty;
  assign receiver_data   = reset ? WORD_WIDTH'(rx_head) : '0;
  assign tx_valid        = reset & ~tx_empty;
  assign tx_data         = reset ? tx_head : '0;
  assign rx_ready        = reset & ~rx_full;
  assign tx_level        = reset ? tx_lvl : '0;
  assign rx_level        = reset ? rx_lvl : '0;

  if (WORD_WIDTH > 8) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^global_data[WORD_WIDTH-1:8];
  end

endmodule

// File: tb/tb_uarc_console_bridge.sv
// Bench for uarc_console_bridge: hand vector table, corner sequences, random run vs queue model.
module tb_uarc_console_bridge;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset, global_send, sender_enable, receiver_send_ack;
  logic [31:0] global_data;
  logic        sender_send_ack, receiver_enable, receiver_send;
  logic [31:0] receiver_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic [7:0]  tx_data, rx_data;
  logic [4:0]  tx_level, rx_level;

  always #5 clk = ~clk;

  uarc_console_bridge #(.WORD_WIDTH(32), .FIFO_ADDR_WIDTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .global_send       (global_send),
    .global_data       (global_data),
    .sender_enable     (sender_enable),
    .sender_send_ack   (sender_send_ack),
    .receiver_enable   (receiver_enable),
    .receiver_send     (receiver_send),
    .receiver_data     (receiver_data),
    .receiver_send_ack (receiver_send_ack),
    .tx_valid          (tx_valid),
    .tx_data           (tx_data),
    .tx_ready          (tx_ready),
    .rx_valid          (rx_valid),
    .rx_data           (rx_data),
    .rx_ready          (rx_ready),
    .tx_level          (tx_level),
    .rx_level          (rx_level)
  );

  int vecs = 0;
  int miscompares = 0;

  // Reference model: byte queues plus the "ack owed" flag of the last accepted word.
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit         ack_m = 1'b0;

  typedef struct {
    logic rst, snd, en; logic [31:0] data; logic trdy, rxv; logic [7:0] rxd; logic rack;
    logic e_ack, e_txv; logic [7:0] e_txd; int e_txl;
    logic e_rxr, e_rs; logic [7:0] e_rd; int e_rxl; logic e_ren;
  } vec_t;

  vec_t tbl[$];
  int   cur_row = -1;

  function automatic vec_t mk(logic rst, logic snd, logic en, logic [31:0] data, logic trdy,
                              logic rxv, logic [7:0] rxd, logic rack, logic e_ack, logic e_txv,
                              logic [7:0] e_txd, int e_txl, logic e_rxr, logic e_rs,
                              logic [7:0] e_rd, int e_rxl, logic e_ren);
    vec_t v;
    v.rst = rst; v.snd = snd; v.en = en; v.data = data; v.trdy = trdy;
    v.rxv = rxv; v.rxd = rxd; v.rack = rack;
    v.e_ack = e_ack; v.e_txv = e_txv; v.e_txd = e_txd; v.e_txl = e_txl;
    v.e_rxr = e_rxr; v.e_rs = e_rs; v.e_rd = e_rd; v.e_rxl = e_rxl; v.e_ren = e_ren;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    bit ok;
    int ts = txq.size();
    int rs = rxq.size();
    vecs++;
    if (!reset) begin
      ok = {sender_send_ack, receiver_enable, receiver_send, receiver_data, tx_valid,
            tx_data, rx_ready, tx_level, rx_level} === '0;
    end else begin
      ok = (sender_send_ack === ack_m) && (tx_valid === (ts != 0)) &&
           (ts == 0 || tx_data === txq[0]) && (int'(tx_level) == ts) &&
           (rx_ready === (rs < DEPTH)) && (receiver_send === (rs != 0)) &&
           (rs == 0 || receiver_data === {24'h0, rxq[0]}) && (int'(rx_level) == rs) &&
           (receiver_enable === 1'b1);
    end
    if (!ok) begin
      miscompares++;
      $display("FAIL model @%0t: got ack=%b txv=%b txd=%h txl=%0d rxr=%b rs=%b rd=%h rxl=%0d en=%b; expected ack=%b txl=%0d txd=%h rxl=%0d rd=%h",
               $time, sender_send_ack, tx_valid, tx_data, tx_level, rx_ready, receiver_send,
               receiver_data, rx_level, receiver_enable, ack_m, ts,
               (ts != 0) ? txq[0] : 8'h0, rs, (rs != 0) ? rxq[0] : 8'h0);
    end
  endtask

  task automatic check_row(int i);
    vec_t v = tbl[i];
    logic [30:0] act, exp;
    act = {sender_send_ack, tx_valid, tx_valid ? tx_data : 8'h0, tx_level, rx_ready,
           receiver_send, receiver_send ? receiver_data[7:0] : 8'h0, rx_level, receiver_enable};
    exp = {v.e_ack, v.e_txv, v.e_txv ? v.e_txd : 8'h0, 5'(v.e_txl), v.e_rxr,
           v.e_rs, v.e_rs ? v.e_rd : 8'h0, 5'(v.e_rxl), v.e_ren};
    vecs++;
    if (act !== exp || receiver_data[31:8] !== 24'h0) begin
      miscompares++;
      $display("FAIL row%0d: got %h (rd_hi=%h) expected %h", i, act, receiver_data[31:8], exp);
    end
  endtask

  task automatic model_edge();
    int  ts = txq.size();
    int  rs = rxq.size();
    bit  acc;
    if (!reset) begin
      txq.delete(); rxq.delete(); ack_m = 1'b0;
    end else begin
      acc = global_send && sender_enable && ts < DEPTH && !ack_m;
      if (tx_ready && ts > 0) void'(txq.pop_front());
      if (acc) txq.push_back(global_data[7:0]);
      if (receiver_send_ack && rs > 0) void'(rxq.pop_front());
      if (rx_valid && rs < DEPTH) rxq.push_back(rx_data);
      ack_m = acc;
    end
  endtask

  // One clock: check mid-cycle, then advance the model on the edge.
  task automatic cyc();
    #4;
    check_model();
    if (cur_row >= 0) check_row(cur_row);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(logic rst, logic snd, logic en, logic [31:0] d, logic trdy,
                       logic rxv, logic [7:0] rxd, logic rack);
    reset = rst; global_send = snd; sender_enable = en; global_data = d;
    tx_ready = trdy; rx_valid = rxv; rx_data = rxd; receiver_send_ack = rack;
  endtask

  initial begin
    int acks, k;
    bit seen;
    drive(0, 1, 1, 32'hDEAD_BEEF, 0, 1, 8'h55, 0);
    @(posedge clk); #1;

    //        rst snd en data          trdy rxv rxd   rack | ack txv txd   txl rxr rs rd    rxl ren
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 1, 32'hDEAD_BEEF, 0, 1, 8'h55, 0,  0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,         0, 0, 8'h00, 0,  0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 1, 1, 32'hDEAD_BE48, 0, 0, 8'h00, 0,  0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,         0, 0, 8'h00, 0,  1, 1, 8'h48, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,         0, 0, 8'h00, 0,  0, 1, 8'h48, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,         0, 1, 8'h48, 0,  0, 1, 8'h48, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,         0, 1, 8'h49, 0,  0, 1, 8'h48, 1, 1, 1, 8'h48, 1, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,         0, 0, 8'h00, 1,  0, 1, 8'h48, 1, 1, 1, 8'h48, 2, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,         0, 0, 8'h00, 1,  0, 1, 8'h48, 1, 1, 1, 8'h49, 1, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,         0, 0, 8'h00, 0,  0, 1, 8'h48, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,         1, 0, 8'h00, 0,  0, 1, 8'h48, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,         0, 0, 8'h00, 0,  0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,         0, 1, 8'hA0, 0,  0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,         0, 1, 8'hA1, 1,  0, 0, 8'h00, 0, 1, 1, 8'hA0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,         0, 0, 8'h00, 0,  0, 0, 8'h00, 0, 1, 1, 8'hA1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,         0, 0, 8'h00, 1,  0, 0, 8'h00, 0, 1, 1, 8'hA1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,         0, 0, 8'h00, 0,  0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].snd, tbl[i].en, tbl[i].data, tbl[i].trdy,
            tbl[i].rxv, tbl[i].rxd, tbl[i].rack);
      cur_row = i;
      cyc();
    end
    cur_row = -1;

    // TX fill under back-pressure: exactly DEPTH ack pulses, then none.
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1, 1, 1, $urandom, 0, 0, 8'h00, 0);
      cyc();
      if (sender_send_ack) acks++;
    end
    chk("tx_full_acks", acks, DEPTH);
    chk("tx_full_level", tx_level, DEPTH);
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    seen = 1'b0;
    for (k = 0; k < 3 && !seen; k++) begin
      if (sender_send_ack) seen = 1'b1;
      else cyc();
    end
    chk("tx_ack_after_free", seen, 1);
    drive(1, 0, 0, 32'h0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 40 && tx_level != 0; i++) cyc();
    chk("tx_drained", tx_level, 0);

    // RX fill to full; the 17th byte must be refused.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 0, 32'h0, 0, 1, 8'($urandom), 0);
      cyc();
    end
    chk("rx_full_ready", rx_ready, 0);
    chk("rx_full_level", rx_level, DEPTH);
    rx_data = 8'hEE;
    cyc(); cyc();
    chk("rx_17th_refused", rx_level, DEPTH);
    drive(1, 0, 0, 32'h0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 40 && receiver_send; i++) cyc();
    chk("rx_drained", rx_level, 0);

    // Reset mid-operation with queued data and an accept pending.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 32'h0, 0, 1, 8'(8'h30 + i), 0);
      cyc();
    end
    drive(1, 1, 1, 32'h0000_0077, 0, 0, 8'h00, 0);
    for (int i = 0; i < 20 && tx_level != 5; i++) cyc();
    chk("rst_pre_txl", tx_level, 5);
    chk("rst_pre_rxl", rx_level, 3);
    cyc();
    reset = 1'b0;
    cyc();
    drive(1, 0, 0, 32'h0, 0, 0, 8'h00, 0);
    chk("rst_txl", tx_level, 0);
    chk("rst_rxl", rx_level, 0);
    chk("rst_no_ack", sender_send_ack, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_rs", receiver_send, 0);
    cyc();
    chk("rst_no_ack2", sender_send_ack, 0);

    // Random traffic, alternating drain-heavy and fill-heavy phases.
    for (int i = 0; i < 2000; i++) begin
      bit slow = ((i / 200) % 2) == 0;
      drive($urandom_range(99) != 0, $urandom_range(3) != 0, $urandom_range(3) != 0, $urandom,
            slow ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0),
            $urandom_range(1) == 0, 8'($urandom),
            slow ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
